psum_acc: RTL and testbench
===========================

PSUM_ACC -- requirements
Module: psum_acc

Interface
REQ-001 SHALL have parameter col, default 8, the number of array columns (lanes).
REQ-002 SHALL have parameter psum_bw, default 16, the bits per lane of psum.
REQ-003 SHALL have parameter npix, default 36, the output vectors per kij pass.
REQ-004 SHALL have parameter nkij, default 9, the kernel positions per accumulation.
REQ-005 SHALL have parameter base_addr, default 0, the first PMEM address of the psum region.
REQ-006 SHALL provide ports as listed, clock and reset first:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- acc_start  in  1  one-cycle pulse that begins one kij pass.
- kij  in  4  kernel index of the pass, sampled at acc_start.
- ofifo_out  in  psum_bw*col  head vector of the ofifo; valid while ofifo_valid=1.
- ofifo_valid  in  1  the ofifo holds at least one vector.
- ofifo_rd  out  1  pop strobe; the head advances at the clock edge.
- OP_q  in  psum_bw*col  PMEM read data, one cycle after a read.
- OP_d  out  psum_bw*col  PMEM write data.
- OP_addr  out  9  PMEM address.
- OP_cen  out  1  PMEM chip enable, active-low.
- OP_wen  out  1  PMEM write enable, active-low.
- busy  out  1  a pass is in progress.
- acc_done  out  1  one-cycle pulse when a pass completes.

Function
REQ-007 SHALL implement states IDLE, FETCH, ACC and DONE.
REQ-008 In IDLE, acc_start SHALL latch kij, clear the vector counter cnt to 0, and move to FETCH.
REQ-009 acc_start SHALL be ignored whenever busy=1.
REQ-010 In FETCH with ofifo_valid=1, the block SHALL register ofifo_out into hold_reg, assert ofifo_rd for this cycle only, drive OP_cen=0, OP_wen=1, OP_addr=base_addr+cnt, and move to ACC.
REQ-011 In FETCH with ofifo_valid=0, the block SHALL stall with ofifo_rd=0 and OP_cen=1.
REQ-012 In ACC, the block SHALL drive OP_cen=0, OP_wen=0, OP_addr=base_addr+cnt, and OP_d=result.
REQ-013 In ACC, if kij==0, result SHALL equal hold_reg and OP_q SHALL be ignored.
REQ-014 In ACC, if kij!=0, result SHALL be the per-lane signed sum hold_reg+OP_q, wrapping at psum_bw bits with no saturation and no carry between lanes.
REQ-015 When kij==nkij-1, each lane with a negative result SHALL be written as 0 (ReLU); other passes SHALL write unclipped results.
REQ-016 At the end of ACC, if cnt==npix-1 the block SHALL go to DONE; otherwise it SHALL increment cnt and return to FETCH.
REQ-017 Throughput SHALL be one vector per 2 cycles when ofifo_valid stays high.
REQ-018 DONE SHALL assert acc_done for exactly 1 cycle and then return to IDLE.
REQ-019 busy SHALL be 1 in FETCH, ACC and DONE, and 0 in IDLE.
REQ-020 ofifo_rd SHALL never be asserted while ofifo_valid=0.
REQ-021 No more than npix pops SHALL occur per pass.
REQ-022 Outside FETCH-with-read and ACC, outputs SHALL be OP_cen=1, OP_wen=1, OP_d=0, OP_addr=base_addr+cnt.

Reset
REQ-023 reset SHALL asynchronously force state=IDLE, cnt=0, kij_reg=0, hold_reg=0.
REQ-024 During reset, outputs SHALL be ofifo_rd=0, OP_cen=1, OP_wen=1, OP_d=0, busy=0, acc_done=0.
REQ-025 Reset mid-pass SHALL abort the pass without a further PMEM write; PMEM contents are not cleared and already-written vectors stay as written.

Structure
REQ-026 The state enum and the default parameters (col, psum_bw, npix, nkij) SHALL live in a shared package reused by corelet.
REQ-027 One sub-module, psum_lane_add, SHALL implement a single lane's wrap add with optional ReLU; it SHALL be instantiated col times.

Verification
REQ-028 The bench SHALL cover: kij=0 pass with 36 vectors of lane value 5 -> PMEM[0..35] all lanes 5; 36 pops; acc_done 72 cycles after the first FETCH with no stalls.
REQ-029 The bench SHALL cover: kij=1 pass with lanes 3 over PMEM preloaded with 5 -> all lanes 8.
REQ-030 The bench SHALL cover: kij=8 pass with lane -7 (0xFFF9) over PMEM holding 4 -> lane written 0; lane +2 over 4 -> 6.
REQ-031 The bench SHALL cover: 0x7FFF+0x0001 with kij=3 -> 0x8000 written, neighbouring lanes unaffected.
REQ-032 The bench SHALL cover: ofifo_valid low for 10 cycles mid-pass -> no pops and no PMEM access during the gap; final PMEM identical to the no-stall run.
REQ-033 The bench SHALL cover: reset at vector 20 -> OP_cen=1 and busy=0 immediately; PMEM[0..19] updated and PMEM[20..35] unchanged; a new acc_start is accepted afterwards.

Source files
------------

// File: rtl/psum_acc_pkg.sv
// psum_acc_pkg: shared definitions for the partial-sum accumulator and corelet.
// Holds the accumulator FSM state type and the default array geometry.
package psum_acc_pkg;

  // Default array geometry, reused by corelet when it instantiates psum_acc.
  localparam int unsigned default_col     = 8;
  localparam int unsigned default_psum_bw = 16;
  localparam int unsigned default_npix    = 36;
  localparam int unsigned default_nkij    = 9;

  // PMEM address width seen by the accumulator.
  localparam int unsigned pmem_aw = 9;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StAcc   = 2'd2,
    StDone  = 2'd3
  } acc_state_e;

endpackage

// File: rtl/psum_acc_lane_add.sv
// psum_lane_add: one lane of the partial-sum datapath.
// Ports:
//   a       - lane of the vector popped from the ofifo
//   b       - lane of the PMEM read data
//   add_en  - 1: sum = a + b (wrapping), 0: sum = a
//   relu_en - 1: negative sums are clipped to 0
//   sum     - lane result written back to PMEM
module psum_lane_add #(
  parameter int unsigned psum_bw = 16
) (
  input  logic [psum_bw-1:0] a,
  input  logic [psum_bw-1:0] b,
  input  logic               add_en,
  input  logic               relu_en,
  output logic [psum_bw-1:0] sum
);

  logic [psum_bw-1:0] raw;

  // Two's-complement add truncated to the lane width: signed wrap, no saturation.
  assign raw = add_en ? (a + b) : a;

  assign sum = (relu_en && raw[psum_bw-1]) ? '0 : raw;

endmodule

// File: rtl/psum_acc.sv
// psum_acc: accumulates one kij pass of ofifo output vectors into PMEM.
// Each vector takes two cycles: FETCH pops the ofifo and reads PMEM, ACC writes
// the (optionally summed and ReLU-clipped) result back to the same address.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   acc_start    - pulse starting a pass (ignored while busy)
//   kij          - kernel index of the pass, sampled with acc_start
//   ofifo_out    - head vector of the ofifo, ofifo_valid - head is valid
//   ofifo_rd     - pop strobe
//   OP_q         - PMEM read data, OP_d/OP_addr/OP_cen/OP_wen - PMEM controls
//   busy         - pass in progress, acc_done - one-cycle pass-complete pulse
module psum_acc
  import psum_acc_pkg::*;
#(
  parameter int unsigned col       = default_col,
  parameter int unsigned psum_bw   = default_psum_bw,
  parameter int unsigned npix      = default_npix,
  parameter int unsigned nkij      = default_nkij,
  parameter int unsigned base_addr = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     acc_start,
  input  logic [3:0]               kij,
  input  logic [psum_bw*col-1:0]   ofifo_out,
  input  logic                     ofifo_valid,
  output logic                     ofifo_rd,
  input  logic [psum_bw*col-1:0]   OP_q,
  output logic [psum_bw*col-1:0]   OP_d,
  output logic [pmem_aw-1:0]       OP_addr,
  output logic                     OP_cen,
  output logic                     OP_wen,
  output logic                     busy,
  output logic                     acc_done
);

  localparam int unsigned cnt_w = (npix > 1) ? $clog2(npix) : 1;

  acc_state_e state_q, state_d;

  logic [cnt_w-1:0]         cnt_q;
  logic [3:0]               kij_q;
  logic [psum_bw*col-1:0]   hold_q;
  logic [psum_bw*col-1:0]   result;
  logic                     last_vec;
  logic                     add_en;
  logic                     relu_en;

  assign last_vec = (cnt_q == cnt_w'(npix - 1));
  // The first kernel position overwrites PMEM; later ones accumulate onto it.
  assign add_en   = (kij_q != 4'd0);
  assign relu_en  = (kij_q == 4'(nkij - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (acc_start) state_d = StFetch;
      StFetch: if (ofifo_valid) state_d = StAcc;
      StAcc:   state_d = last_vec ? StDone : StFetch;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      kij_q  <= '0;
      hold_q <= '0;
    end else begin
      if (state_q == StIdle && acc_start) begin
        kij_q <= kij;
        cnt_q <= '0;
      end
      if (state_q == StFetch && ofifo_valid) begin
        hold_q <= ofifo_out;
      end
      if (state_q == StAcc && !last_vec) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < col; i++) begin : g_lane
    psum_lane_add #(
      .psum_bw (psum_bw)
    ) u_lane (
      .a       (hold_q[i*psum_bw +: psum_bw]),
      .b       (OP_q[i*psum_bw +: psum_bw]),
      .add_en  (add_en),
      .relu_en (relu_en),
      .sum     (result[i*psum_bw +: psum_bw])
    );
  end

  // Output logic
  always_comb begin
    ofifo_rd = 1'b0;
    OP_cen   = 1'b1;
    OP_wen   = 1'b1;
    OP_d     = '0;
    OP_addr  = pmem_aw'(base_addr) + pmem_aw'(cnt_q);
    busy     = 1'b1;
    acc_done = 1'b0;
    unique case (state_q)
      StIdle: busy = 1'b0;
      StFetch: begin
        // Pop and PMEM read happen together so OP_q lines up with hold_q in ACC.
        if (ofifo_valid) begin
          ofifo_rd = 1'b1;
          OP_cen   = 1'b0;
        end
      end
      StAcc: begin
        OP_cen = 1'b0;
        OP_wen = 1'b0;
        OP_d   = result;
      end
      StDone: acc_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_psum_acc.sv
// tb_psum_acc: directed bench for psum_acc with a behavioural ofifo and PMEM.
module tb_psum_acc;

  localparam int unsigned Col = 8;
  localparam int unsigned Bw  = 16;
  localparam int unsigned W   = Col * Bw;
  localparam int unsigned Npix = 36;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         acc_start = 1'b0;
  logic [3:0]   kij = '0;
  logic [W-1:0] ofifo_out;
  logic         ofifo_valid;
  logic         ofifo_rd;
  logic [W-1:0] OP_q;
  logic [W-1:0] OP_d;
  logic [8:0]   OP_addr;
  logic         OP_cen;
  logic         OP_wen;
  logic         busy;
  logic         acc_done;

  psum_acc dut (
    .clk         (clk),
    .reset       (reset),
    .acc_start   (acc_start),
    .kij         (kij),
    .ofifo_out   (ofifo_out),
    .ofifo_valid (ofifo_valid),
    .ofifo_rd    (ofifo_rd),
    .OP_q        (OP_q),
    .OP_d        (OP_d),
    .OP_addr     (OP_addr),
    .OP_cen      (OP_cen),
    .OP_wen      (OP_wen),
    .busy        (busy),
    .acc_done    (acc_done)
  );

  always #5 clk = ~clk;

  // Behavioural ofifo (Npix copies of fifo_vec) and PMEM.
  logic [W-1:0] mem [512];
  logic [W-1:0] fifo_vec = '0;
  logic [W-1:0] preload = '0;
  logic [W-1:0] op_q_r = '0;
  logic         gate = 1'b1;
  logic         prep_req = 1'b0;
  int           rdptr = 0;
  int           pops = 0;
  int           accs = 0;
  int           bad_rd = 0;
  int           cyc = 0;

  assign ofifo_valid = gate && (rdptr < Npix);
  assign ofifo_out   = (rdptr < Npix) ? fifo_vec : {(W/16){16'hDEAD}};
  assign OP_q        = op_q_r;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (prep_req) begin
      for (int i = 0; i < 512; i++) mem[i] <= preload;
      rdptr <= 0;
      pops  <= 0;
      accs  <= 0;
    end else begin
      if (ofifo_rd) begin
        pops  <= pops + 1;
        rdptr <= rdptr + 1;
        if (!ofifo_valid) bad_rd <= bad_rd + 1;
      end
      if (!OP_cen) begin
        accs <= accs + 1;
        if (!OP_wen) mem[OP_addr] <= OP_d;
        else         op_q_r <= mem[OP_addr];
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [15:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < Col; i++) r[i*Bw +: Bw] = v;
    return r;
  endfunction

  task automatic prep(input logic [W-1:0] fv, input logic [W-1:0] pv);
    @(negedge clk);
    fifo_vec = fv;
    preload  = pv;
    prep_req = 1'b1;
    @(negedge clk);
    prep_req = 1'b0;
  endtask

  task automatic start_pass(input logic [3:0] k);
    @(negedge clk);
    acc_start = 1'b1;
    kij       = k;
    @(negedge clk);
    acc_start = 1'b0;
  endtask

  // Runs one pass to completion; with_gap drops ofifo_valid for 10 cycles mid-pass.
  task automatic run_pass(input string tag, input logic [3:0] k, input bit with_gap);
    int c0;
    int snap_pops;
    int snap_accs;
    bit done;
    start_pass(k);
    c0 = cyc;
    check({tag, " busy_at_start"}, W'(busy), W'(1));
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      if (acc_done) begin
        done = 1'b1;
      end else begin
        if (with_gap && pops == 10 && gate) begin
          gate = 1'b0;
          @(negedge clk);
          snap_pops = pops;
          snap_accs = accs;
          repeat (9) @(negedge clk);
          check({tag, " gap_pops"}, W'(pops), W'(snap_pops));
          check({tag, " gap_pmem"}, W'(accs), W'(snap_accs));
          gate = 1'b1;
        end
        @(negedge clk);
      end
    end
    check({tag, " done_seen"}, W'(done), W'(1));
    if (!with_gap) check({tag, " done_latency"}, W'(cyc - c0), W'(72));
    check({tag, " pops"}, W'(pops), W'(Npix));
    @(negedge clk);
    check({tag, " done_pulse_1cyc"}, W'(acc_done), W'(0));
    check({tag, " idle_after"}, W'(busy), W'(0));
  endtask

  task automatic check_mem(input string tag, input int lo, input int hi,
                           input logic [W-1:0] exp);
    for (int a = lo; a <= hi; a++) check($sformatf("%s mem[%0d]", tag, a), mem[a], exp);
  endtask

  initial begin
    logic [W-1:0] fv;
    logic [W-1:0] ev;
    bit seen;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst busy", W'(busy), W'(0));
    check("rst acc_done", W'(acc_done), W'(0));
    check("rst ofifo_rd", W'(ofifo_rd), W'(0));
    check("rst cen", W'(OP_cen), W'(1));
    check("rst wen", W'(OP_wen), W'(1));
    check("rst op_d", OP_d, '0);
    reset = 1'b0;

    // kij=0: overwrite, PMEM garbage must be ignored; address 36 untouched.
    prep(rep(16'd5), rep(16'h1234));
    run_pass("kij0", 4'd0, 1'b0);
    check_mem("kij0", 0, 35, rep(16'd5));
    check("kij0 mem[36]", mem[36], rep(16'h1234));

    // kij=1: 3 + 5 = 8
    prep(rep(16'd3), rep(16'd5));
    run_pass("kij1", 4'd1, 1'b0);
    check_mem("kij1", 0, 35, rep(16'd8));

    // kij=8 (last): ReLU, -7+4 -> 0, 2+4 -> 6
    for (int i = 0; i < Col; i++) begin
      fv[i*Bw +: Bw] = (i % 2 == 0) ? 16'hFFF9 : 16'h0002;
      ev[i*Bw +: Bw] = (i % 2 == 0) ? 16'h0000 : 16'h0006;
    end
    prep(fv, rep(16'd4));
    run_pass("kij8", 4'd8, 1'b0);
    check_mem("kij8", 0, 1, ev);
    check("kij8 mem[35]", mem[35], ev);

    // kij=3: per-lane wrap, no carry into neighbours
    fv = rep(16'h0001);
    fv[15:0]  = 16'h7FFF;
    fv[31:16] = 16'hFFFF;
    ev = rep(16'h0002);
    ev[15:0]  = 16'h8000;
    ev[31:16] = 16'h0000;
    prep(fv, rep(16'h0001));
    run_pass("wrap", 4'd3, 1'b0);
    check_mem("wrap", 0, 0, ev);
    check("wrap mem[35]", mem[35], ev);

    // Stall mid-pass: same final PMEM as the kij1 run
    prep(rep(16'd3), rep(16'd5));
    run_pass("gap", 4'd1, 1'b1);
    check_mem("gap", 0, 35, rep(16'd8));

    // Reset while vector 20 is in ACC: its write must not happen
    prep(rep(16'd3), rep(16'd5));
    start_pass(4'd1);
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (pops >= 21) seen = 1'b1;
      else @(negedge clk);
    end
    check("abort reached_vec20", W'(seen), W'(1));
    check("abort in_acc", W'(OP_wen), W'(0));
    reset = 1'b1;
    #1;
    check("abort cen", W'(OP_cen), W'(1));
    check("abort busy", W'(busy), W'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_mem("abort", 19, 19, rep(16'd8));
    check("abort mem[0]", mem[0], rep(16'd8));
    check_mem("abort", 20, 21, rep(16'd5));
    check("abort mem[35]", mem[35], rep(16'd5));

    // New pass accepted after the abort
    prep(rep(16'd9), rep(16'd5));
    run_pass("restart", 4'd0, 1'b0);
    check_mem("restart", 0, 0, rep(16'd9));
    check("restart mem[35]", mem[35], rep(16'd9));

    check("no_pop_when_empty", W'(bad_rd), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
